rom_arbiter: RTL

Two-port arbiter and access sequencer for the single-port instruction ROM (`InstMem`). It shares the ROM between the instruction-fetch stage (IF) and a load port (LS) that reads constants or jump tables from instruction memory. It grants one access per cycle using round-robin and drives the ROM enable and address from registers. Each read is returned to its owner with fixed latency, and in-flight IF reads can be flushed on a branch.

---
 rtl/rom_arbiter_pkg.sv | 18 +
 rtl/rom_arbiter_if.sv | 41 ++++
 rtl/rom_arbiter_rr_arb2.sv | 37 +++
 rtl/rom_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/rom_arbiter_pkg.sv
// Shared constants, owner encoding and helpers for the instruction-ROM arbiter.
package rom_arbiter_pkg;

    localparam logic ROMCE_ENABLE  = 1'b1;
    localparam logic ROMCE_DISABLE = 1'b0;
    localparam logic RST_ENABLE    = 1'b0;

    // Owner value doubles as the bit index of that port's grant.
    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } owner_e;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Bundle of IF/LS request-response ports and the ROM access port of rom_arbiter.
interface rom_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_flush;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_rerr;

    logic              ls_req;
    logic [ADDR_W-1:0] ls_addr;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_rerr;

    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    // The arbiter is the slave; requesters and the ROM sit on the master side.
    modport slave (
        input  if_req, if_addr, if_flush, ls_req, ls_addr, rom_data,
        output if_gnt, if_rvalid, if_rdata, if_rerr,
        output ls_gnt, ls_rvalid, ls_rdata, ls_rerr,
        output rom_ce, rom_addr
    );

    modport master (
        output if_req, if_addr, if_flush, ls_req, ls_addr, rom_data,
        input  if_gnt, if_rvalid, if_rdata, if_rerr,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_rerr,
        input  rom_ce, rom_addr
    );

endinterface

// File: rtl/rom_arbiter_rr_arb2.sv
// Two-way round-robin picker; remembers which port was granted most recently.
module rr_arb2
    import rom_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    owner_e last_q, last_d;

    // On a tie the port that did not win last time is picked.
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = (last_q == OWNER_LS) ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (accept_i) begin
            last_d = gnt_o[1] ? OWNER_LS : OWNER_IF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            last_q <= OWNER_LS;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the single-port instruction ROM between fetch (IF) and load (LS) ports
// with a fixed two-cycle read pipeline and flush of in-flight fetches.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    rom_arbiter_if.slave bus
);

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              accept;
    owner_e            acc_own;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_err;

    logic              s1_v_q, s1_v_d;
    owner_e            s1_own_q, s1_own_d;
    logic              s1_err_q, s1_err_d;
    logic              rom_ce_q, rom_ce_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

    logic              s1_kill;
    logic [DATA_W-1:0] resp_data;
    logic              s2_v_q, s2_v_d;
    owner_e            s2_own_q, s2_own_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              if_rerr_q, if_rerr_d;
    logic              ls_rerr_q, ls_rerr_d;

    // A flushing fetch stage must not start a new read in the same cycle.
    assign req    = {bus.ls_req, bus.if_req && !bus.if_flush};
    assign accept = |gnt;

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    always_comb begin
        acc_own  = gnt[1] ? OWNER_LS : OWNER_IF;
        acc_addr = gnt[1] ? bus.ls_addr : bus.if_addr;
        acc_err  = is_misaligned(acc_addr[1:0]);
    end

    // Misaligned reads still occupy a slot but never touch the ROM.
    always_comb begin
        s1_v_d     = accept;
        s1_own_d   = acc_own;
        s1_err_d   = acc_err;
        rom_ce_d   = (accept && !acc_err) ? ROMCE_ENABLE : ROMCE_DISABLE;
        rom_addr_d = accept ? acc_addr : rom_addr_q;
    end

    // A flush drops the fetch still in S1; whatever sits in S2 is already visible.
    always_comb begin
        s1_kill    = bus.if_flush && s1_v_q && (s1_own_q == OWNER_IF);
        s2_v_d     = s1_v_q && !s1_kill;
        s2_own_d   = s1_own_q;
        resp_data  = s1_err_q ? '0 : bus.rom_data;
        if_rdata_d = if_rdata_q;
        if_rerr_d  = if_rerr_q;
        ls_rdata_d = ls_rdata_q;
        ls_rerr_d  = ls_rerr_q;
        if (s2_v_d) begin
            if (s1_own_q == OWNER_IF) begin
                if_rdata_d = resp_data;
                if_rerr_d  = s1_err_q;
            end else begin
                ls_rdata_d = resp_data;
                ls_rerr_d  = s1_err_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            s1_v_q     <= 1'b0;
            s1_own_q   <= OWNER_IF;
            s1_err_q   <= 1'b0;
            rom_ce_q   <= ROMCE_DISABLE;
            rom_addr_q <= '0;
            s2_v_q     <= 1'b0;
            s2_own_q   <= OWNER_IF;
            if_rdata_q <= '0;
            if_rerr_q  <= 1'b0;
            ls_rdata_q <= '0;
            ls_rerr_q  <= 1'b0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_own_q   <= s1_own_d;
            s1_err_q   <= s1_err_d;
            rom_ce_q   <= rom_ce_d;
            rom_addr_q <= rom_addr_d;
            s2_v_q     <= s2_v_d;
            s2_own_q   <= s2_own_d;
            if_rdata_q <= if_rdata_d;
            if_rerr_q  <= if_rerr_d;
            ls_rdata_q <= ls_rdata_d;
            ls_rerr_q  <= ls_rerr_d;
        end
    end

    assign bus.if_gnt    = gnt[0];
    assign bus.ls_gnt    = gnt[1];
    assign bus.rom_ce    = rom_ce_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.if_rvalid = s2_v_q && (s2_own_q == OWNER_IF);
    assign bus.ls_rvalid = s2_v_q && (s2_own_q == OWNER_LS);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_rerr   = if_rerr_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.ls_rerr   = ls_rerr_q;

endmodule
